move_ctrl: RTL and testbench
============================

# move_ctrl

Parametrised two-axis position controller that turns four push-button inputs into X/Y duty-cycle codes for the PWM stage. Compared with the first-generation mover it adds input synchronisation, one step per press instead of one step per clock, hold-to-repeat with a configurable initial delay and repeat period, and a one-cycle step strobe per axis. It sits between the board buttons and the PWM duty inputs in the F5 design.

## Interface
- W, 6: width of each duty code.
- STEP, 4: increment per step, 1..2^W-1.
- MAX_POS, 2^W-1: upper bound, used only when saturation is compiled in.
- HOLD_DLY, 25_000_000: cycles from the first step to the first auto-repeat step, ≥2.
- RPT_PER, 5_000_000: cycles between auto-repeat steps, ≥2.
- CNT_W, 25: width of the delay counter; must hold max(HOLD_DLY, RPT_PER)-1.

- sysclk  in  1  system clock, all logic on the rising edge.
- Reset_Sw_n  in  1  asynchronous, active-low reset.
- Bt_Up / Bt_Down  in  1 each  asynchronous buttons, Y+ / Y-.
- Bt_Left / Bt_Right  in  1 each  asynchronous buttons, X- / X+.
- DC_X / DC_Y  out  W each  duty codes, registered.
- Step_X / Step_Y  out  1 each  one-cycle pulse in the cycle the matching DC_* changes.

## Operation
- Each button passes through a 2-flop synchroniser. Reset value of the synchronisers is 0.
- The two axes are independent and identical. Each axis has a (pos, neg) pair: Y = (Up, Down), X = (Right, Left).
- Axis FSM states: IDLE, WAIT, RPT. Each axis has one down-counter of width CNT_W.
- "Valid request": exactly one of pos/neg is asserted after synchronisation. Both asserted, or neither, is not a request.
- IDLE:
  - On a valid request, apply one step in the requested direction.
  - Load the counter with HOLD_DLY-1 and go to WAIT.
- WAIT:
  - If the synchronised {pos,neg} pair differs from the pair captured on entry, go to IDLE with no step. This covers release, both pressed, and a direction swap.
  - Otherwise, if the counter is 0, step, load RPT_PER-1 and go to RPT. If not, decrement the counter.
- RPT: same rules as WAIT, but reloads RPT_PER-1 after each step.
- A direction swap costs exactly one IDLE cycle. The new direction steps on the following cycle.
- Step arithmetic without saturation is modulo 2^W. Examples: 60+4 gives 0; 0-4 gives 60.
- Step_* is asserted for exactly the cycle in which DC_* takes its new value. Step_* is never asserted when the value is unchanged.
- Reset asserted at any time forces the following, regardless of FSM state or pending counters:
  - DC_X = DC_Y = 0.
  - Step_X = Step_Y = 0.
  - Both FSMs to IDLE.
  - Counters to 0.
  - Synchronisers to 0.
- After reset release, a button that is already held counts as a fresh press.

## Timing
- Latency from press to DC change: a button high before edge n is in sync stage 2 after edge n+1. DC_* and Step_* update at edge n+2.
- Auto-repeat: the first repeat step is HOLD_DLY cycles after the first step. Every later step is RPT_PER cycles after the previous one.
- Release latency: a release before edge n stops further steps from edge n+2. No step is issued on the exit cycle.
- Outputs come straight from flops. There is no combinational path from inputs to outputs.

## Configuration
- MOVE_SATURATE_EN:
  - Defined: steps clamp to [0, MAX_POS]. Clamping examples: 58+4 with MAX_POS=60 gives 60; 2-4 gives 0.
  - Defined: a step that would leave the value unchanged because it is already at the bound produces no Step_* pulse. The FSM still sequences normally.
  - Undefined: modulo-2^W wrap, and MAX_POS is ignored.

## Test plan
Bench parameters: W=6, STEP=4, HOLD_DLY=8, RPT_PER=4.
- Reset: hold Reset_Sw_n=0 with all buttons pressed, then release. DC_X=DC_Y=0 and Step_*=0 during reset. Exactly one step fires at edge 3 after release, because held buttons count as fresh presses.
- Single tap: pulse Bt_Up for 3 cycles from DC_Y=0. DC_Y=4 with one Step_Y pulse at press edge+2, and no further change.
- Hold: keep Bt_Right high for 30 cycles. DC_X steps at cycles 2, 10, 14, 18, 22, 26, 30 relative to the press, ending at 28, with one Step_X per step.
- Conflict and swap: Bt_Up and Bt_Down together → DC_Y unchanged, no Step_Y. Then swap Up→Down while held from DC_Y=8 → a single IDLE cycle, then DC_Y=4.
- Wrap (macro undefined): Bt_Left tap from DC_X=0 → 60. Bt_Right tap from DC_X=60 → 0.
- Saturate (MOVE_SATURATE_EN defined, MAX_POS=60): hold Bt_Up from DC_Y=52 → 56, 60, then stays at 60 with no further Step_Y. Bt_Down tap from DC_Y=2 → 0.

Source files
------------

// File: rtl/move_ctrl.sv
// move_ctrl: two-axis push-button position controller feeding PWM duty codes.
// Build option: define MOVE_SATURATE_EN to clamp to [0, MAX_POS] instead of wrapping.
module move_axis #(
    parameter int W        = 6,
    parameter int STEP     = 4,
    parameter int MAX_POS  = 2**W - 1,
    parameter int HOLD_DLY = 25_000_000,
    parameter int RPT_PER  = 5_000_000,
    parameter int CNT_W    = 25
) (
    input  logic         sysclk,
    input  logic         rst_n,
    input  logic         pos,
    input  logic         neg,
    output logic [W-1:0] dc,
    output logic         step
);
    typedef enum logic [1:0] {IDLE, WAIT, RPT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_DLY - 1);
    localparam logic [CNT_W-1:0] RPT_LD  = CNT_W'(RPT_PER - 1);
    localparam logic [W:0]       STEP_V  = (W+1)'(STEP);
`ifdef MOVE_SATURATE_EN
    localparam logic [W:0]       MAX_V   = (W+1)'(MAX_POS);
`endif

    if (STEP < 1 || STEP > 2**W - 1 || MAX_POS > 2**W - 1 ||
        HOLD_DLY < 2 || RPT_PER < 2) begin : g_bad_cfg
        $error("move_axis: parameter out of range");
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       pair, pair_n;
    logic             go;
    logic [W:0]       sum, dif;
    logic [W-1:0]     up_v, dn_v, dc_n;

    // Next state: step on a fresh request, then hold-delay and repeat.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pair_n  = pair;
        go      = 1'b0;
        unique case (state)
            IDLE: begin
                if (pos ^ neg) begin
                    go      = 1'b1;
                    cnt_n   = HOLD_LD;
                    pair_n  = {pos, neg};
                    state_n = WAIT;
                end
            end
            WAIT, RPT: begin
                if ({pos, neg} != pair) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    go      = 1'b1;
                    cnt_n   = RPT_LD;
                    state_n = RPT;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Candidate position after one step; pos alone selects direction.
    always_comb begin
        sum = {1'b0, dc} + STEP_V;
        dif = {1'b0, dc} - STEP_V;
`ifdef MOVE_SATURATE_EN
        up_v = (sum > MAX_V) ? MAX_V[W-1:0] : sum[W-1:0];
        dn_v = dif[W] ? '0 : dif[W-1:0];
`else
        up_v = sum[W-1:0];
        dn_v = dif[W-1:0];
`endif
        dc_n = pos ? up_v : dn_v;
    end

    // State, counter and registered outputs; strobe only on a real change.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pair  <= '0;
            dc    <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pair  <= pair_n;
            step  <= go && (dc_n != dc);
            if (go) begin
                dc <= dc_n;
            end
        end
    end
endmodule

module move_ctrl #(
    parameter int W        = 6,
    parameter int STEP     = 4,
    parameter int MAX_POS  = 2**W - 1,
    parameter int HOLD_DLY = 25_000_000,
    parameter int RPT_PER  = 5_000_000,
    parameter int CNT_W    = 25
) (
    input  logic         sysclk,
    input  logic         Reset_Sw_n,
    input  logic         Bt_Up,
    input  logic         Bt_Down,
    input  logic         Bt_Left,
    input  logic         Bt_Right,
    output logic [W-1:0] DC_X,
    output logic [W-1:0] DC_Y,
    output logic         Step_X,
    output logic         Step_Y
);
    logic [3:0] sync1, sync2;

    // Two-flop synchronisers, order {up, down, right, left}.
    always_ff @(posedge sysclk or negedge Reset_Sw_n) begin
        if (!Reset_Sw_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {Bt_Up, Bt_Down, Bt_Right, Bt_Left};
            sync2 <= sync1;
        end
    end

    move_axis #(
        .W(W), .STEP(STEP), .MAX_POS(MAX_POS),
        .HOLD_DLY(HOLD_DLY), .RPT_PER(RPT_PER), .CNT_W(CNT_W)
    ) u_x (
        .sysclk(sysclk), .rst_n(Reset_Sw_n),
        .pos(sync2[1]), .neg(sync2[0]),
        .dc(DC_X), .step(Step_X)
    );

    move_axis #(
        .W(W), .STEP(STEP), .MAX_POS(MAX_POS),
        .HOLD_DLY(HOLD_DLY), .RPT_PER(RPT_PER), .CNT_W(CNT_W)
    ) u_y (
        .sysclk(sysclk), .rst_n(Reset_Sw_n),
        .pos(sync2[3]), .neg(sync2[2]),
        .dc(DC_Y), .step(Step_Y)
    );
endmodule

// File: tb/tb_move_ctrl.sv
// tb_move_ctrl: random and directed button stimulus for move_ctrl.
// Outputs are compared every cycle against a schedule-based model.
module tb_move_ctrl;
    localparam int W = 6, STEP = 4, MAX_POS = 60;
    localparam int HOLD = 8, RPT = 4, CNT_W = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0;
    logic [W-1:0] dc_x, dc_y;
    logic st_x, st_y;
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    move_ctrl #(
        .W(W), .STEP(STEP), .MAX_POS(MAX_POS),
        .HOLD_DLY(HOLD), .RPT_PER(RPT), .CNT_W(CNT_W)
    ) dut (
        .sysclk(clk), .Reset_Sw_n(rst_n),
        .Bt_Up(up), .Bt_Down(dn), .Bt_Left(lf), .Bt_Right(rt),
        .DC_X(dc_x), .DC_Y(dc_y), .Step_X(st_x), .Step_Y(st_y)
    );

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d at %0t", name, got, exp, $time);
    endtask

    // Model: a run starts on a valid pair; steps fall at run ages
    // 0, HOLD, HOLD+RPT, ...; any change of the seen pair ends the run.
    int m_dc[2], m_age[2];
    bit m_st[2], m_act[2];
    logic [1:0] m_pr[2];
    logic [3:0] m_s1 = '0, m_s2 = '0;

    function automatic bit due(input int age);
        return age == 0 || age == HOLD ||
               (age > HOLD && (age - HOLD) % RPT == 0);
    endfunction

    function automatic int move(input int v, input bit pos);
        int r;
        r = pos ? v + STEP : v - STEP;
`ifdef MOVE_SATURATE_EN
        if (r > MAX_POS) r = MAX_POS;
        if (r < 0) r = 0;
`else
        r = (r + (1 << W)) % (1 << W);
`endif
        return r;
    endfunction

    initial begin
        logic [1:0] pr;
        bit fire;
        int nv;
        for (int a = 0; a < 2; a++) begin
            m_dc[a] = 0; m_st[a] = 0; m_act[a] = 0;
            m_age[a] = 0; m_pr[a] = '0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int a = 0; a < 2; a++) begin
                    m_dc[a] = 0; m_st[a] = 0; m_act[a] = 0;
                    m_age[a] = 0; m_pr[a] = '0;
                end
                m_s1 = '0;
                m_s2 = '0;
            end else begin
                for (int a = 0; a < 2; a++) begin
                    pr = (a == 1) ? m_s2[3:2] : m_s2[1:0];
                    fire = 0;
                    if (m_act[a]) begin
                        if (pr != m_pr[a]) begin
                            m_act[a] = 0;
                        end else begin
                            m_age[a]++;
                            fire = due(m_age[a]);
                        end
                    end else if (pr == 2'b10 || pr == 2'b01) begin
                        m_act[a] = 1;
                        m_pr[a] = pr;
                        m_age[a] = 0;
                        fire = 1;
                    end
                    m_st[a] = 0;
                    if (fire) begin
                        nv = move(m_dc[a], m_pr[a][1]);
                        m_st[a] = (nv != m_dc[a]);
                        m_dc[a] = nv;
                    end
                end
                m_s2 = m_s1;
                m_s1 = {up, dn, rt, lf};
            end
        end
    end

    // Every-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        check("dc_x", dc_x, m_dc[0]);
        check("dc_y", dc_y, m_dc[1]);
        check("step_x", st_x, m_st[0]);
        check("step_y", st_y, m_st[1]);
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b, input int hold, input int idle);
        {up, dn, rt, lf} = b;
        wait_n(hold);
        {up, dn, rt, lf} = '0;
        wait_n(idle);
    endtask

    initial begin
        logic [3:0] b;
        int d;
        // Reset with Up and Right already held.
        up = 1'b1;
        rt = 1'b1;
        wait_n(3);
        check("rst_dc_x", dc_x, 0);
        check("rst_dc_y", dc_y, 0);
        check("rst_step_x", st_x, 0);
        rst_n = 1'b1;
        wait_n(2);
        check("rel_e2_dc_x", dc_x, 0);
        check("rel_e2_step_y", st_y, 0);
        wait_n(1);
        check("rel_e3_dc_x", dc_x, 4);
        check("rel_e3_dc_y", dc_y, 4);
        check("rel_e3_step_x", st_x, 1);
        check("rel_e3_step_y", st_y, 1);
        {up, dn, rt, lf} = '0;
        wait_n(8);
        // Single tap.
        press(4'b1000, 3, 8);
        check("tap_dc_y", dc_y, 8);
        // Long hold with auto-repeat.
        press(4'b0010, 30, 8);
        check("hold_dc_x", dc_x, 32);
        // Conflict.
        press(4'b1100, 10, 8);
        check("conflict_dc_y", dc_y, 8);
        // Direction swap while held.
        {up, dn, rt, lf} = 4'b1000;
        wait_n(4);
        {up, dn, rt, lf} = 4'b0100;
        wait_n(3);
        check("swap_idle_dc_y", dc_y, 12);
        check("swap_idle_step_y", st_y, 0);
        wait_n(1);
        check("swap_dc_y", dc_y, 8);
        check("swap_step_y", st_y, 1);
        wait_n(2);
        {up, dn, rt, lf} = '0;
        wait_n(8);
        check("swap_end_dc_y", dc_y, 8);
        // Walk X down to 0, then cross the lower bound.
        repeat (8) press(4'b0001, 3, 6);
        check("walk_dc_x", dc_x, 0);
        press(4'b0001, 3, 6);
`ifdef MOVE_SATURATE_EN
        check("sat_lo_dc_x", dc_x, 0);
        press(4'b0010, 3, 6);
        check("sat_up_dc_x", dc_x, 4);
        press(4'b1000, 60, 8);
        check("sat_hi_dc_y", dc_y, 60);
`else
        check("wrap_lo_dc_x", dc_x, 60);
        press(4'b0010, 3, 6);
        check("wrap_hi_dc_x", dc_x, 0);
`endif
        // Random phase, with occasional mid-activity resets.
        repeat (150) begin
            d = $urandom_range(1, 30);
            if ($urandom_range(0, 1) == 1) b = 4'($urandom);
            else b = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                wait_n(2);
                rst_n = 1'b1;
            end
            {up, dn, rt, lf} = b;
            wait_n(d);
        end
        {up, dn, rt, lf} = '0;
        wait_n(20);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
